// File: rtl/contador_display_driver.sv
// rtl/contador_display_driver.sv - registers a 0..15 count, tracks direction/sweeps, scans a 2-digit 7-seg display
// Optional build macro: BLANK_ZERO_EN (blank the tens digit for values below 10)
module contador_display_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter int CYCLE_W     = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [3:0]         valor_in,
    output logic [6:0]         seg,
    output logic [1:0]         an,
    output logic               dir_up,
    output logic [CYCLE_W-1:0] ciclos
);

    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [1:0] AN_UNITS  = 2'b10;
    localparam logic [1:0] AN_TENS   = 2'b01;

    // Active-low segment pattern for one decimal digit; bit0=a .. bit6=g
    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h40;
            4'd1:    p = 7'h79;
            4'd2:    p = 7'h24;
            4'd3:    p = 7'h30;
            4'd4:    p = 7'h19;
            4'd5:    p = 7'h12;
            4'd6:    p = 7'h02;
            4'd7:    p = 7'h78;
            4'd8:    p = 7'h00;
            4'd9:    p = 7'h10;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

    logic [3:0]         val_q, val_d;
    logic [3:0]         prev_q, prev_d;
    logic               dir_q, dir_d;
    logic [CYCLE_W-1:0] ciclos_q, ciclos_d;
    logic [REF_W-1:0]   refresh_q, refresh_d;
    logic               sel_tens_q, sel_tens_d;
    logic [1:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;

    logic               ge_ten;
    logic [3:0]         tens;
    logic [3:0]         units;
    logic [6:0]         tens_pat;

    // Decimal split of the registered value and the pattern shown in the tens slot
    always_comb begin
        ge_ten = (val_q >= 4'd10);
        tens   = ge_ten ? 4'd1 : 4'd0;
        units  = ge_ten ? (val_q - 4'd10) : val_q;
`ifdef BLANK_ZERO_EN
        tens_pat = ge_ten ? enc(tens) : SEG_BLANK;
`else
        tens_pat = enc(tens);
`endif
    end

    // Next-state: input pipeline, direction/sweep tracking, scan timing, output patterns
    always_comb begin
        val_d      = valor_in;
        prev_d     = val_q;
        dir_d      = dir_q;
        ciclos_d   = ciclos_q;
        refresh_d  = refresh_q + REF_W'(1);
        sel_tens_d = sel_tens_q;

        if (val_q > prev_q) begin
            dir_d = 1'b1;
        end else if (val_q < prev_q) begin
            dir_d = 1'b0;
        end

        // A sweep completes when a descent turns back into an ascent
        if (!dir_q && dir_d) begin
            ciclos_d = ciclos_q + CYCLE_W'(1);
        end

        if (refresh_q == REF_LAST) begin
            refresh_d  = '0;
            sel_tens_d = ~sel_tens_q;
        end

        if (sel_tens_q) begin
            an_d  = AN_TENS;
            seg_d = tens_pat;
        end else begin
            an_d  = AN_UNITS;
            seg_d = enc(units);
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clock) begin
        if (reset) begin
            val_q      <= 4'd0;
            prev_q     <= 4'd0;
            dir_q      <= 1'b1;
            ciclos_q   <= '0;
            refresh_q  <= '0;
            sel_tens_q <= 1'b0;
            an_q       <= AN_UNITS;
            seg_q      <= 7'h40;
        end else begin
            val_q      <= val_d;
            prev_q     <= prev_d;
            dir_q      <= dir_d;
            ciclos_q   <= ciclos_d;
            refresh_q  <= refresh_d;
            sel_tens_q <= sel_tens_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign seg    = seg_q;
    assign an     = an_q;
    assign dir_up = dir_q;
    assign ciclos = ciclos_q;

endmodule

// File: tb/tb_contador_display_driver.sv
// tb/tb_contador_display_driver.sv - self-checking bench for contador_display_driver
module tb_contador_display_driver;

    localparam int R  = 4;
    localparam int CW = 2;
`ifdef BLANK_ZERO_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    valor_in = 4'd0;
    logic [6:0]    seg, seg1;
    logic [1:0]    an, an1;
    logic          dir_up, dir_up1;
    logic [CW-1:0] ciclos;
    logic [7:0]    ciclos1;

    contador_display_driver #(.REFRESH_DIV(R), .CYCLE_W(CW)) dut (
        .clock(clock), .reset(reset), .valor_in(valor_in),
        .seg(seg), .an(an), .dir_up(dir_up), .ciclos(ciclos)
    );

    contador_display_driver #(.REFRESH_DIV(1), .CYCLE_W(8)) dut1 (
        .clock(clock), .reset(reset), .valor_in(valor_in),
        .seg(seg1), .an(an1), .dir_up(dir_up1), .ciclos(ciclos1)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int hist [0:4095];
    int t = 0;
    logic [6:0] enc_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // hist[k] = value captured on the k-th clock after reset (hist[0] = reset value)
    function automatic int exp_seg(int tt, int r);
        int v;
        if (tt == 0) return 'h40;
        v = hist[tt-1];
        if (((tt - 1) / r) % 2 == 0) return int'(enc_tab[v % 10]);
        if (BLANK && v < 10) return 'h7F;
        return int'(enc_tab[v / 10]);
    endfunction

    function automatic int exp_an(int tt, int r);
        if (tt == 0) return 2;
        return ((((tt - 1) / r) % 2) == 1) ? 1 : 2;
    endfunction

    // Direction = sign of the most recent non-zero step seen by the design
    function automatic int exp_dir(int tt);
        int d = 1;
        for (int j = 1; j <= tt - 1; j++) begin
            if (hist[j] > hist[j-1]) d = 1;
            else if (hist[j] < hist[j-1]) d = 0;
        end
        return d;
    endfunction

    // Sweeps = number of non-zero steps upward that follow a downward trend
    function automatic int exp_cic(int tt, int w);
        int d = 1;
        int c = 0;
        for (int j = 1; j <= tt - 1; j++) begin
            if (hist[j] > hist[j-1]) begin
                if (d == 0) c++;
                d = 1;
            end else if (hist[j] < hist[j-1]) begin
                d = 0;
            end
        end
        return c % (1 << w);
    endfunction

    task automatic step(input int v);
        valor_in = 4'(v);
        @(posedge clock);
        t++;
        hist[t] = v;
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clock);
        #1;
        reset = 1'b0;
        t = 0;
        hist[0] = 0;
    endtask

    task automatic test_reset();
        valor_in = 4'd9;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            n_tests++;
            if (seg !== 7'h40 || an !== 2'b10 || dir_up !== 1'b1 || ciclos !== '0) begin
                n_fail++;
                $display("FAIL reset_state: got seg=%h an=%b dir=%b cic=%0d expected seg=40 an=10 dir=1 cic=0", seg, an, dir_up, ciclos);
            end
            n_tests++;
            if (seg1 !== 7'h40 || an1 !== 2'b10 || ciclos1 !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_state_div1: got seg=%h an=%b cic=%0d expected seg=40 an=10 cic=0", seg1, an1, ciclos1);
            end
        end
        reset = 1'b0;
        t = 0;
        hist[0] = 0;
    endtask

    task automatic test_digit_display();
        do_reset(2);
        for (int i = 0; i < 3 * R + 2; i++) begin
            step(12);
            n_tests++;
            if (an !== 2'(exp_an(t, R))) begin
                n_fail++;
                $display("FAIL digit_an t=%0d: got %b expected %b", t, an, 2'(exp_an(t, R)));
            end
            if (t >= 2) begin
                n_tests++;
                if (exp_an(t, R) == 2 && seg !== 7'h24) begin
                    n_fail++;
                    $display("FAIL digit_units t=%0d: got %h expected 24", t, seg);
                end else if (exp_an(t, R) == 1 && seg !== 7'h79) begin
                    n_fail++;
                    $display("FAIL digit_tens t=%0d: got %h expected 79", t, seg);
                end
            end
        end
    endtask

    task automatic test_direction();
        int seq [$];
        do_reset(2);
        for (int v = 0; v <= 15; v++) seq.push_back(v);
        seq.push_back(15);
        seq.push_back(14);
        seq.push_back(14);
        seq.push_back(14);
        foreach (seq[k]) begin
            step(seq[k]);
            n_tests++;
            if (dir_up !== 1'(exp_dir(t))) begin
                n_fail++;
                $display("FAIL direction t=%0d: got %b expected %b", t, dir_up, 1'(exp_dir(t)));
            end
            n_tests++;
            if (ciclos !== '0) begin
                n_fail++;
                $display("FAIL direction_ciclos t=%0d: got %0d expected 0", t, ciclos);
            end
        end
        n_tests++;
        if (dir_up !== 1'b0) begin
            n_fail++;
            $display("FAIL direction_fall: got %b expected 0", dir_up);
        end
    endtask

    task automatic test_sweep();
        do_reset(2);
        for (int v = 1; v <= 15; v++) step(v);
        for (int s = 0; s < 4; s++) begin
            for (int v = 15; v >= 0; v--) step(v);
            step(0);
            step(1);
            step(1);
            n_tests++;
            if (ciclos !== CW'(exp_cic(t, CW)) || dir_up !== 1'(exp_dir(t))) begin
                n_fail++;
                $display("FAIL sweep_model s=%0d: got cic=%0d dir=%b expected cic=%0d dir=%0d", s, ciclos, dir_up, exp_cic(t, CW), exp_dir(t));
            end
            if (s == 0) begin
                n_tests++;
                if (ciclos !== CW'(1)) begin
                    n_fail++;
                    $display("FAIL sweep_first: got %0d expected 1", ciclos);
                end
            end
            for (int v = 2; v <= 15; v++) step(v);
        end
        n_tests++;
        if (ciclos !== CW'(0)) begin
            n_fail++;
            $display("FAIL sweep_wrap: got %0d expected 0", ciclos);
        end
        n_tests++;
        if (ciclos1 !== 8'd4) begin
            n_fail++;
            $display("FAIL sweep_wide: got %0d expected 4", ciclos1);
        end
    endtask

    task automatic test_blank();
        do_reset(2);
        for (int i = 0; i < 2 * R + 2; i++) begin
            step(7);
            if (t >= 2 && exp_an(t, R) == 1) begin
                n_tests++;
                if (seg !== (BLANK ? 7'h7F : 7'h40)) begin
                    n_fail++;
                    $display("FAIL blank_tens_7 t=%0d: got %h expected %h", t, seg, BLANK ? 7'h7F : 7'h40);
                end
            end
        end
        for (int i = 0; i < 2 * R + 2; i++) begin
            step(10);
            if (hist[t-1] == 10 && exp_an(t, R) == 1) begin
                n_tests++;
                if (seg !== 7'h79) begin
                    n_fail++;
                    $display("FAIL blank_tens_10 t=%0d: got %h expected 79", t, seg);
                end
            end
        end
    endtask

    task automatic test_random();
        int v = 0;
        do_reset(2);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 15));
            else if ($urandom_range(0, 1) == 1 && v < 15) v++;
            else if (v > 0 && $urandom_range(0, 2) != 0) v--;
            step(v);
            n_tests++;
            if (seg !== 7'(exp_seg(t, R)) || an !== 2'(exp_an(t, R))) begin
                n_fail++;
                $display("FAIL random_display t=%0d: got seg=%h an=%b expected seg=%h an=%b", t, seg, an, 7'(exp_seg(t, R)), 2'(exp_an(t, R)));
            end
            n_tests++;
            if (dir_up !== 1'(exp_dir(t)) || ciclos !== CW'(exp_cic(t, CW))) begin
                n_fail++;
                $display("FAIL random_dir t=%0d: got dir=%b cic=%0d expected dir=%0d cic=%0d", t, dir_up, ciclos, exp_dir(t), exp_cic(t, CW));
            end
            n_tests++;
            if (seg1 !== 7'(exp_seg(t, 1)) || an1 !== 2'(exp_an(t, 1)) || ciclos1 !== 8'(exp_cic(t, 8))) begin
                n_fail++;
                $display("FAIL random_div1 t=%0d: got seg=%h an=%b cic=%0d expected seg=%h an=%b cic=%0d", t, seg1, an1, ciclos1, 7'(exp_seg(t, 1)), 2'(exp_an(t, 1)), exp_cic(t, 8));
            end
        end
    endtask

    task automatic test_mid_reset();
        int seq [9] = '{1, 0, 1, 0, 1, 0, 1, 0, 0};
        bit found = 1'b0;
        do_reset(2);
        foreach (seq[k]) step(seq[k]);
        for (int i = 0; i < 2 * R + 2 && !found; i++) begin
            step(0);
            if (an === 2'b01) found = 1'b1;
        end
        n_tests++;
        if (!found || dir_up !== 1'b0 || ciclos !== CW'(3)) begin
            n_fail++;
            $display("FAIL mid_reset_setup: got found=%0d an=%b dir=%b cic=%0d expected found=1 an=01 dir=0 cic=3", found, an, dir_up, ciclos);
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        n_tests++;
        if (an !== 2'b10 || seg !== 7'h40 || dir_up !== 1'b1 || ciclos !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_state: got an=%b seg=%h dir=%b cic=%0d expected an=10 seg=40 dir=1 cic=0", an, seg, dir_up, ciclos);
        end
        reset = 1'b0;
        t = 0;
        hist[0] = 0;
        for (int k = 1; k <= R + 1; k++) begin
            step(3);
            n_tests++;
            if (an !== ((k <= R) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL mid_reset_restart k=%0d: got %b expected %b", k, an, (k <= R) ? 2'b10 : 2'b01);
            end
        end
    endtask

    initial begin
        test_reset();
        test_digit_display();
        test_direction();
        test_sweep();
        test_blank();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
